// File: rtl/range_stream_reader.sv
// range_stream_reader
//   Circular queue of DW-bit entries filled through a push port. A range
//   command [cmd_start, cmd_end] (signed offsets from the queue head) is
//   streamed out one entry per beat on a valid/ready handshake, with
//   out_last marking the final offset.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   push_valid/push_data append an entry at the tail
//   push_overflow        one-cycle pulse after a push was dropped (queue full)
//   cmd_valid/cmd_ready  range command handshake (ready only in IDLE)
//   cmd_start/cmd_end    signed first/last offset from head, inclusive
//   cmd_err              one-cycle pulse after an invalid command is accepted
//   out_valid/out_ready  stream handshake
//   out_data/out_last    entry at head+cur, final-beat flag
//   q_size               registered entry count
//
// Build option
//   RANGE_STREAM_POP_EN  when defined, a completed command with start==0
//                        removes the streamed entries from the queue head.
//
// States
//   S_IDLE   | waiting for a command, cmd_ready high
//   S_STREAM | emitting beats cur..last, head pointer frozen
module range_stream_reader #(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic [DW-1:0]            push_data,
  output logic                     push_overflow,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic signed [31:0]       cmd_start,
  input  logic signed [31:0]       cmd_end,
  output logic                     cmd_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   q_size
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] hd_q, hd_d;
  logic [AW-1:0] tl_q, tl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [AW-1:0] last_q, last_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;

  logic [DW-1:0] mem [DEPTH];

  logic          push_acc;
  logic          range_ok;
  logic [31:0]   cnt_ext;
  logic [31:0]   end_u;
  logic [AW-1:0] rd_idx;
  logic [CW-1:0] pop_amt;

`ifdef RANGE_STREAM_POP_EN
  logic pop_q, pop_d;
`endif

  always_comb begin
    state_d  = state_q;
    hd_d     = hd_q;
    tl_d     = tl_q;
    cur_d    = cur_q;
    last_d   = last_q;
    err_d    = 1'b0;
    pop_amt  = '0;
`ifdef RANGE_STREAM_POP_EN
    pop_d    = pop_q;
`endif

    // Fullness is judged on the registered count, so a pop completing this
    // cycle does not make room for a same-cycle push.
    push_acc = push_valid && (cnt_q < CW'(DEPTH));
    ovf_d    = push_valid && !push_acc;
    if (push_acc) tl_d = tl_q + AW'(1);

    cnt_ext  = {{(32-CW){1'b0}}, cnt_q};
    end_u    = cmd_end;
    range_ok = !cmd_start[31] && !cmd_end[31] && (cmd_start <= cmd_end) &&
               (end_u < cnt_ext);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (range_ok) begin
            // end < cnt <= DEPTH, so both offsets fit in a pointer.
            cur_d   = cmd_start[AW-1:0];
            last_d  = cmd_end[AW-1:0];
            state_d = S_STREAM;
`ifdef RANGE_STREAM_POP_EN
            pop_d   = (cmd_start == 32'sd0);
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (out_ready) begin
          if (cur_q == last_q) begin
            state_d = S_IDLE;
`ifdef RANGE_STREAM_POP_EN
            if (pop_q) begin
              hd_d    = hd_q + last_q + AW'(1);
              pop_amt = CW'(last_q) + CW'(1);
            end
`endif
          end else begin
            cur_d = cur_q + AW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    cnt_d = cnt_q + CW'(push_acc) - pop_amt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hd_q    <= '0;
      tl_q    <= '0;
      cnt_q   <= '0;
      cur_q   <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hd_q    <= hd_d;
      tl_q    <= tl_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef RANGE_STREAM_POP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pop_q <= 1'b0;
    else     pop_q <= pop_d;
  end
`endif

  // Storage needs no reset; reads are gated by the FSM.
  always_ff @(posedge clk) begin
    if (push_acc) mem[tl_q] <= push_data;
  end

  assign rd_idx        = hd_q + cur_q;
  assign cmd_ready     = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_STREAM);
  assign out_data      = out_valid ? mem[rd_idx] : '0;
  assign out_last      = out_valid && (cur_q == last_q);
  assign cmd_err       = err_q;
  assign push_overflow = ovf_q;
  assign q_size        = cnt_q;

endmodule

// File: doc/range_stream_reader.md
# range_stream_reader

Streaming read-out side of the queue-slice blocks. The block holds a circular queue of `DW`-bit entries filled through a push port. It accepts a range command `[start, end]`, given as offsets from the queue head, and streams those entries out one per beat over a valid/ready handshake, flagging the final beat. Downstream consumers use it to drain or inspect queue slices element by element.

## Interface
Parameters:
- `DEPTH`, default 8: queue capacity in entries; power of two, ≥ 2.
- `DW`, default 32: entry width in bits.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `push_valid` in 1: push `push_data` this cycle.
- `push_data` in `DW`: entry to append at the tail.
- `push_overflow` out 1: one-cycle pulse when a push is dropped because the queue is full.
- `cmd_valid` in 1: range command present.
- `cmd_ready` out 1: block can accept a command; high only in IDLE.
- `cmd_start` in 32, signed: first offset from head.
- `cmd_end` in 32, signed: last offset from head, inclusive.
- `cmd_err` out 1: one-cycle pulse when an accepted command has an invalid range.
- `out_valid` out 1: stream beat valid.
- `out_ready` in 1: consumer accepts the beat.
- `out_data` out `DW`: entry at offset `cmd_start + beat`.
- `out_last` out 1: current beat is offset `cmd_end`.
- `q_size` out `$clog2(DEPTH)+1`: current entry count.

## Operation
- Storage: circular buffer with head pointer `hd`, tail pointer `tl` and count `cnt`. Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
- Push:
  - If `push_valid` is high and `cnt < DEPTH`, write `mem[tl]`, advance `tl` and increment `cnt`.
  - If the queue is full, drop the entry and pulse `push_overflow`.
  - Pushes are legal in every state.
- FSM states are IDLE and STREAM.
- IDLE:
  - `cmd_ready`=1.
  - A command is accepted on `cmd_valid & cmd_ready`.
  - The range is valid iff `start ≥ 0`, `end ≥ 0`, `start ≤ end` and `end < cnt`. `cnt` is sampled in the acceptance cycle, before any same-cycle push.
  - Valid range: latch `cur=start`, `last=end`; go to STREAM.
  - Invalid range: pulse `cmd_err` the next cycle and stay in IDLE; no output beat is produced.
- STREAM:
  - `out_valid`=1, `out_data = mem[(hd+cur) mod DEPTH]`, `out_last = (cur==last)`.
  - On `out_ready`, increment `cur`.
  - On the beat where `out_last` is high and `out_ready` is high, return to IDLE.
  - While `out_ready` is low, `out_data` and `out_last` hold stable.
- Pushes during STREAM land at the tail and never alter offsets already in range, because `hd` is fixed during STREAM.

## Timing
- Reset values: `hd`=`tl`=`cnt`=0, FSM in IDLE, `cmd_ready`=1, `out_valid`=0, `out_last`=0, `out_data`=0, `cmd_err`=0, `push_overflow`=0, `q_size`=0.
- Command latency: a command accepted in cycle N gives `out_valid` high in cycle N+1.
- Throughput is one beat per cycle while `out_ready` is held high. A range of length L is consumed in L cycles.
- `cmd_ready` is low from the cycle after acceptance through the final beat. It is high again the cycle after the last handshake, so back-to-back commands have a one-cycle bubble.
- `q_size` reflects the registered `cnt`; it updates the cycle after a push or pop.
- A `cmd_err` pulse and a `push_overflow` pulse may occur in the same cycle.
- Reset asserted mid-stream immediately clears `out_valid`, empties the queue and returns the FSM to IDLE.

## Configuration
- `RANGE_STREAM_POP_EN` defined:
  - On completion of a command with `start==0`, the streamed entries are removed: `hd += end+1` and `cnt -= end+1`.
  - If a push is accepted in that same cycle, `cnt` becomes `cnt + 1 - (end+1)`.
  - Commands with `start>0` do not pop.
- `RANGE_STREAM_POP_EN` undefined: streaming is non-destructive and `hd` only changes on reset.

## Test plan
- Push 10, 20, 30, 40; command [1,2] with `out_ready`=1 → beats 20, then 30 with `out_last`; `q_size` stays 4 without the macro.
- Command [2,1], command [-1,0], and command [0,4] with `cnt`=4 → each gives a `cmd_err` pulse, no `out_valid`, and the FSM stays in IDLE.
- Push 9 entries into `DEPTH`=8 → `push_overflow` pulses on the 9th push and `q_size`=8; command [7,7] returns the 8th value.
- Stream [0,3] while toggling `out_ready` 1,0,0,1,… → `out_data` holds during stalls and exactly 4 handshakes complete, in order.
- With `RANGE_STREAM_POP_EN`: push 1..6, stream [0,2] with a push of 7 on the last beat → `q_size`=4 next cycle; command [0,0] then returns 4.
- Wrap-around: 6 pushes, pop 5 (macro build), push 6 more, command [0,6] → correct values across the index 7→0 boundary; assert `rst` on the third beat → `out_valid`=0 and `q_size`=0 immediately.
